// File: rtl/alarm_trigger_pkg.sv
// Shared types and constants for the alarm trigger.
// Optional snooze feature: ALARM_SNOOZE_EN.
package alarm_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_DONE   = 2'd2,
    ST_SNOOZE = 2'd3
  } state_e;

  localparam logic [7:0] HOUR_MAX     = 8'h23;
  localparam logic [7:0] MIN_MAX      = 8'h59;
  localparam logic [1:0] SNOOZE_LIMIT = 2'd3;

endpackage

// File: rtl/alarm_trigger_bcd_wrap_inc.sv
// Two-digit BCD increment that wraps to 00 after max_i.
// Used for both the alarm hour and the alarm minute.
module bcd_wrap_inc
  import alarm_trigger_pkg::*;
(
  input  logic [7:0] bcd_i,
  input  logic [7:0] max_i,
  output logic [7:0] bcd_o
);

  // Wrap at the limit, carry into tens on a units digit of 9
  always_comb begin
    bcd_o = 8'h00;
    if (bcd_i == max_i) begin
      bcd_o = 8'h00;
    end else if (bcd_i[3:0] == 4'd9) begin
      bcd_o = {bcd_i[7:4] + 4'd1, 4'd0};
    end else begin
      bcd_o = {bcd_i[7:4], bcd_i[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/alarm_trigger.sv
// Alarm time store, match detect, ring FSM and step prescaler.
// Optional snooze feature: ALARM_SNOOZE_EN.
module alarm_trigger
  import alarm_trigger_pkg::*;
#(
  parameter int STEP_DIV     = 12_500_000,
  parameter int SNOOZE_STEPS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power,
  input  logic       alarm_on,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic       set_en,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_snooze,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic       sig_ring,
  output logic       sig_step
);

  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(STEP_DIV / 2);

  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic          sig_step_q;
  logic          btn_hour_q, btn_min_q;
  logic          hour_edge, min_edge;
  logic [7:0]    alarm_hour_q, alarm_min_q;
  logic [7:0]    hour_nxt, min_nxt;
  state_e        state_q;
  logic          ring_q;
  logic          edge_seen_q;
  logic          match;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_STEPS + 1);
  logic          btn_snz_q;
  logic          snz_edge;
  logic [1:0]    snz_cnt_q;
  logic [SW-1:0] snz_cd_q;
  assign snz_edge = btn_snooze & ~btn_snz_q;
`else
  logic snooze_unused;
  assign snooze_unused = btn_snooze | (SNOOZE_STEPS == 0);
`endif

  assign step_cnt_d = (step_cnt_q == CNT_LAST) ? '0
                    : step_cnt_q + CW'(1);
  assign hour_edge  = btn_hour & ~btn_hour_q;
  assign min_edge   = btn_min & ~btn_min_q;

  assign match = power & alarm_on & ~set_en
               & (cur_hour == alarm_hour_q)
               & (cur_min == alarm_min_q)
               & (cur_sec == 8'h00);

  bcd_wrap_inc u_hour_inc (
    .bcd_i (alarm_hour_q),
    .max_i (HOUR_MAX),
    .bcd_o (hour_nxt)
  );

  bcd_wrap_inc u_min_inc (
    .bcd_i (alarm_min_q),
    .max_i (MIN_MAX),
    .bcd_o (min_nxt)
  );

  // Free-running prescaler and square-wave step output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      sig_step_q <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      sig_step_q <= (step_cnt_q < CNT_HALF);
    end
  end

  // Button history for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_hour_q <= 1'b0;
      btn_min_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      btn_snz_q  <= 1'b0;
`endif
    end else begin
      btn_hour_q <= btn_hour;
      btn_min_q  <= btn_min;
`ifdef ALARM_SNOOZE_EN
      btn_snz_q  <= btn_snooze;
`endif
    end
  end

  // Alarm time edit, one BCD step per button press
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_hour_q <= 8'h00;
      alarm_min_q  <= 8'h00;
    end else if (set_en) begin
      if (hour_edge) alarm_hour_q <= hour_nxt;
      if (min_edge)  alarm_min_q  <= min_nxt;
    end
  end

  // Ring control FSM with registered ring request
  always_ff @(posedge clk) begin
    if (!rst_n || !power || !alarm_on) begin
      state_q     <= ST_IDLE;
      ring_q      <= 1'b0;
      edge_seen_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q   <= 2'd0;
      snz_cd_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match) begin
            state_q <= ST_RING;
            ring_q  <= 1'b1;
          end
        end
        ST_RING: begin
          if (step_cnt_q == '0) edge_seen_q <= 1'b1;
          if (step_cnt_q == CNT_HALF && edge_seen_q) begin
            state_q     <= ST_DONE;
            ring_q      <= 1'b0;
            edge_seen_q <= 1'b0;
          end
        end
        ST_DONE: begin
`ifdef ALARM_SNOOZE_EN
          if (snz_edge && snz_cnt_q < SNOOZE_LIMIT) begin
            state_q   <= ST_SNOOZE;
            snz_cd_q  <= SW'(SNOOZE_STEPS);
            snz_cnt_q <= snz_cnt_q + 2'd1;
          end else if (cur_min != alarm_min_q) begin
            state_q   <= ST_IDLE;
            snz_cnt_q <= 2'd0;
          end
`else
          if (cur_min != alarm_min_q) state_q <= ST_IDLE;
`endif
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (snz_cd_q == '0) begin
            state_q <= ST_RING;
            ring_q  <= 1'b1;
          end else if (step_cnt_q == '0) begin
            snz_cd_q <= snz_cd_q - SW'(1);
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          ring_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_hour = alarm_hour_q;
  assign alarm_min  = alarm_min_q;
  assign sig_ring   = ring_q;
  assign sig_step   = sig_step_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger (STEP_DIV=4, SNOOZE_STEPS=2).
// Snooze checks follow ALARM_SNOOZE_EN.
module tb_alarm_trigger;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       power = 1'b0;
  logic       alarm_on = 1'b0;
  logic [7:0] cur_hour = 8'h00;
  logic [7:0] cur_min = 8'h00;
  logic [7:0] cur_sec = 8'h00;
  logic       set_en = 1'b0;
  logic       btn_hour = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_snooze = 1'b0;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;
  logic       sig_ring;
  logic       sig_step;

  int n_chk = 0;
  int n_err = 0;

  alarm_trigger #(
    .STEP_DIV     (4),
    .SNOOZE_STEPS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .power      (power),
    .alarm_on   (alarm_on),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .set_en     (set_en),
    .btn_hour   (btn_hour),
    .btn_min    (btn_min),
    .btn_snooze (btn_snooze),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .sig_ring   (sig_ring),
    .sig_step   (sig_step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_h();
    btn_hour = 1'b1; cyc(1);
    btn_hour = 1'b0; cyc(1);
  endtask

  task automatic press_m();
    btn_min = 1'b1; cyc(1);
    btn_min = 1'b0; cyc(1);
  endtask

  task automatic press_s();
    btn_snooze = 1'b1; cyc(1);
    btn_snooze = 1'b0;
  endtask

  task automatic set_time(input logic [7:0] h,
                          input logic [7:0] m,
                          input logic [7:0] s);
    cur_hour = h; cur_min = m; cur_sec = s;
  endtask

  task automatic ring_hits(input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (sig_ring) hits++;
    end
  endtask

  task automatic wait_ring(input logic lvl, input int maxc,
                           output int lat);
    lat = 0;
    while (sig_ring !== lvl && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Follow a ring already high until it drops; count step rises inside
  task automatic ring_cover(input string tag);
    logic prev;
    int   rises;
    int   k;
    prev  = sig_step;
    rises = 0;
    k     = 0;
    while (sig_ring && k < 40) begin
      @(negedge clk);
      k++;
      if (sig_ring && !prev && sig_step) rises++;
      prev = sig_step;
    end
    check({tag, "_fell"}, 32'(sig_ring), 32'd0);
    check({tag, "_rises"}, 32'(rises), 32'd1);
  endtask

  initial begin
    int hits;
    int lat;
    logic [7:0] exp_pat [8];
    exp_pat = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};

    cyc(2);
    check("rst_step", 32'(sig_step), 32'd0);
    check("rst_ring", 32'(sig_ring), 32'd0);
    check("rst_hour", 32'(alarm_hour), 32'h00);
    check("rst_min", 32'(alarm_min), 32'h00);

    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check($sformatf("step_%0d", i), 32'(sig_step),
            32'(exp_pat[i]));
    end

    set_en = 1'b1;
    btn_min = 1'b1; cyc(3);
    btn_min = 1'b0; cyc(1);
    check("min_hold", 32'(alarm_min), 32'h01);
    for (int i = 0; i < 58; i++) press_m();
    check("min_59", 32'(alarm_min), 32'h59);
    press_m();
    check("min_wrap", 32'(alarm_min), 32'h00);
    press_m();
    check("min_61", 32'(alarm_min), 32'h01);

    for (int i = 0; i < 10; i++) press_h();
    check("hour_10", 32'(alarm_hour), 32'h10);
    for (int i = 0; i < 13; i++) press_h();
    check("hour_23", 32'(alarm_hour), 32'h23);
    press_h();
    check("hour_24", 32'(alarm_hour), 32'h00);

    btn_hour = 1'b1; btn_min = 1'b1; cyc(1);
    btn_hour = 1'b0; btn_min = 1'b0; cyc(1);
    check("both_h", 32'(alarm_hour), 32'h01);
    check("both_m", 32'(alarm_min), 32'h02);
    for (int i = 0; i < 6; i++) press_h();
    for (int i = 0; i < 28; i++) press_m();
    check("set_h", 32'(alarm_hour), 32'h07);
    check("set_m", 32'(alarm_min), 32'h30);
    set_en = 1'b0;

    power = 1'b1; alarm_on = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    ring_hits(4, hits);
    check("pre_ring", 32'(hits), 32'd0);
    set_time(8'h07, 8'h30, 8'h00);
    cyc(1);
    check("ring1_on", 32'(sig_ring), 32'd1);
    ring_cover("ring1");

    hits = 0;
    for (int i = 1; i < 60; i++) begin
      cur_sec = 8'((i / 10) * 16 + (i % 10));
      cyc(1);
      if (sig_ring) hits++;
    end
    check("no_refire", 32'(hits), 32'd0);

    set_time(8'h07, 8'h31, 8'h00);
    cyc(3);
    set_time(8'h07, 8'h29, 8'h59);
    cyc(3);
    set_time(8'h07, 8'h30, 8'h00);
    cyc(1);
    check("day2_on", 32'(sig_ring), 32'd1);

    power = 1'b0;
    cyc(1);
    check("pwr_drop", 32'(sig_ring), 32'd0);
    cur_sec = 8'h05;
    power = 1'b1;
    ring_hits(12, hits);
    check("pwr_back", 32'(hits), 32'd0);

    set_time(8'h07, 8'h31, 8'h00);
    cyc(2);
    set_en = 1'b1;
    set_time(8'h07, 8'h30, 8'h00);
    ring_hits(6, hits);
    check("set_supp", 32'(hits), 32'd0);
    cur_sec = 8'h01;
    cyc(1);
    set_en = 1'b0;

    set_time(8'h07, 8'h31, 8'h00);
    cyc(2);
    set_time(8'h07, 8'h30, 8'h00);
    cyc(1);
    check("ring3_on", 32'(sig_ring), 32'd1);
    cur_sec = 8'h01;
    wait_ring(1'b0, 40, lat);
    check("ring3_off", 32'(sig_ring), 32'd0);
    cyc(2);

`ifdef ALARM_SNOOZE_EN
    for (int p = 1; p <= 3; p++) begin
      press_s();
      wait_ring(1'b1, 30, lat);
      check($sformatf("snz%0d_on", p), 32'(sig_ring), 32'd1);
      check($sformatf("snz%0d_lat", p),
            32'(lat >= 6 && lat <= 9), 32'd1);
      ring_cover($sformatf("snz%0d", p));
      cyc(2);
    end
    press_s();
    ring_hits(24, hits);
    check("snz4_ign", 32'(hits), 32'd0);
`else
    press_s();
    ring_hits(24, hits);
    check("snz_ign", 32'(hits), 32'd0);
`endif

    set_time(8'h07, 8'h31, 8'h00);
    cyc(2);
    set_time(8'h07, 8'h30, 8'h00);
    cyc(1);
    check("ring4_on", 32'(sig_ring), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    check("rst_mid_ring", 32'(sig_ring), 32'd0);
    check("rst_mid_h", 32'(alarm_hour), 32'h00);
    check("rst_mid_m", 32'(alarm_min), 32'h00);
    rst_n = 1'b1;
    ring_hits(8, hits);
    check("rst_no_done", 32'(hits), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
